axi_master: RTL

- AXI4 write/read initiator that drives the AXI slave port of the FIR subsystem (the `axi` block).
- Accepts a simple command from the FIR control logic: direction, start address and beat count.
- Writes: streams 16-bit samples into the slave as an INCR burst.
- Reads: returns 16-bit samples from the slave as a stream.
- Only one transaction is outstanding at a time; write and read never overlap.

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_lane_mux.sv | 38 +++
 rtl/axi_master.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared types and constants for the FIR subsystem's AXI initiator.
// The state encoding, fixed burst attributes and response codes live here.
package axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA
    } axi_state_t;

    localparam logic [2:0] AXI_SIZE_2B    = 3'b001;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Worst response wins when several beats report status.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_lane_mux.sv
// Places a 16-bit sample into its byte lanes on the write path and picks the
// matching lane from read data; pure combinational, shared by both channels.
module axi_lane_mux #(
    parameter int DATA_W   = 64,
    parameter int SAMPLE_W = 16
) (
    input  logic [$clog2(DATA_W/8)-1:0] beat_addr,
    input  logic [SAMPLE_W-1:0]         wr_sample,
    input  logic [DATA_W-1:0]           rdata,
    output logic [DATA_W-1:0]           wdata,
    output logic [DATA_W/8-1:0]         wstrb,
    output logic [SAMPLE_W-1:0]         rd_sample
);

    localparam int OFF_W  = $clog2(DATA_W/8);
    localparam int LANES  = DATA_W / SAMPLE_W;
    localparam int LANE_W = $clog2(LANES);
    localparam int STRB_W = DATA_W / 8;

    logic [LANE_W-1:0]   lane;
    logic [SAMPLE_W-1:0] rd_lane [LANES];

    // The lowest address bit is the byte within a sample, so the lane index
    // is the address bits just above it.
    assign lane  = beat_addr[OFF_W-1 -: LANE_W];
    assign wstrb = STRB_W'(3) << beat_addr;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign wdata[gi*SAMPLE_W +: SAMPLE_W] = (lane == LANE_W'(gi)) ? wr_sample : '0;
            assign rd_lane[gi] = rdata[gi*SAMPLE_W +: SAMPLE_W];
        end
    endgenerate

    assign rd_sample = rd_lane[lane];

endmodule

// File: rtl/axi_master.sv
// Single-outstanding AXI4 initiator: streams 16-bit samples into the FIR slave
// as an INCR burst, or pulls a burst back out as a sample stream.
module axi_master #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int SAMPLE_W = 16,
    parameter int LEN_W    = 4
) (
    input  logic                  a_clk,
    input  logic                  a_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [SAMPLE_W-1:0]   wr_sample,
    input  logic                  wr_sample_valid,
    output logic                  wr_sample_ready,
    output logic [SAMPLE_W-1:0]   rd_sample,
    output logic                  rd_sample_valid,
    input  logic                  rd_sample_ready,
    output logic                  done,
    output logic [1:0]            resp,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [LEN_W-1:0]      awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_W-1:0]     araddr,
    output logic [LEN_W-1:0]      arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast
);

    import axi_pkg::*;

    localparam int OFF_W = $clog2(DATA_W/8);

    axi_state_t        state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] beat_addr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W:0]    beat_cnt_reg;
    logic [1:0]        resp_reg;
    logic              done_reg;
    logic              awvalid_reg;
    logic              arvalid_reg;

    logic last_beat;
    logic w_hs;
    logic r_hs;

    // beat_cnt is one bit wider than len so a 16-beat burst never wraps it.
    assign last_beat = (beat_cnt_reg == {1'b0, len_reg});
    assign w_hs      = wvalid & wready;
    assign r_hs      = rvalid & rready;

    assign cmd_ready       = (state_reg == ST_IDLE);
    assign wvalid          = (state_reg == ST_WR_DATA) & wr_sample_valid;
    assign wr_sample_ready = w_hs;
    assign wlast           = (state_reg == ST_WR_DATA) & last_beat;
    assign bready          = (state_reg == ST_WR_RESP);
    assign rready          = (state_reg == ST_RD_DATA) & rd_sample_ready;
    assign rd_sample_valid = (state_reg == ST_RD_DATA) & rvalid;

    assign awvalid = awvalid_reg;
    assign awaddr  = addr_reg;
    assign awlen   = len_reg;
    assign awsize  = AXI_SIZE_2B;
    assign awburst = AXI_BURST_INCR;
    assign arvalid = arvalid_reg;
    assign araddr  = addr_reg;
    assign arlen   = len_reg;
    assign arsize  = AXI_SIZE_2B;
    assign arburst = AXI_BURST_INCR;
    assign done    = done_reg;
    assign resp    = resp_reg;

    axi_lane_mux #(
        .DATA_W   (DATA_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_lane_mux (
        .beat_addr (beat_addr_reg[OFF_W-1:0]),
        .wr_sample (wr_sample),
        .rdata     (rdata),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .rd_sample (rd_sample)
    );

    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            beat_addr_reg <= '0;
            len_reg       <= '0;
            beat_cnt_reg  <= '0;
            resp_reg      <= OKAY;
            done_reg      <= 1'b0;
            awvalid_reg   <= 1'b0;
            arvalid_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_reg      <= cmd_addr;
                        beat_addr_reg <= cmd_addr;
                        len_reg       <= cmd_len;
                        beat_cnt_reg  <= '0;
                        resp_reg      <= OKAY;
                        if (cmd_write) begin
                            state_reg   <= ST_WR_ADDR;
                            awvalid_reg <= 1'b1;
                        end else begin
                            state_reg   <= ST_RD_ADDR;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                ST_WR_ADDR: begin
                    if (awready) begin
                        awvalid_reg <= 1'b0;
                        state_reg   <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (w_hs) begin
                        beat_addr_reg <= beat_addr_reg + ADDR_W'(2);
                        beat_cnt_reg  <= beat_cnt_reg + (LEN_W+1)'(1);
                        if (last_beat)
                            state_reg <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid) begin
                        resp_reg  <= bresp;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (arready) begin
                        arvalid_reg <= 1'b0;
                        state_reg   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (r_hs) begin
                        beat_addr_reg <= beat_addr_reg + ADDR_W'(2);
                        beat_cnt_reg  <= beat_cnt_reg + (LEN_W+1)'(1);
                        // A burst whose rlast disagrees with the requested length is an error.
                        if (rlast != last_beat) begin
                            resp_reg  <= SLVERR;
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            resp_reg <= resp_max(resp_reg, rresp);
                            if (last_beat) begin
                                done_reg  <= 1'b1;
                                state_reg <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
